iob_ram_sp_be_ctrl: RTL and testbench



---
 rtl/iob_ram_sp_be_ctrl_if.sv | 30 +++
 rtl/iob_ram_sp_be_ctrl.sv | 134 +++++++++++++
 tb/tb_iob_ram_sp_be_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_ram_sp_be_ctrl_if.sv
// Native word-request / read-response bus between an initiator and the RAM controller.
// Latency: none; this is a plain bundle of wires.
// Backpressure: valid/ready on both the request and the response channel.
interface iob_ram_sp_be_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NB-1:0]     req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    // Initiator side: issues requests, consumes responses.
    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Controller side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/iob_ram_sp_be_ctrl.sv
// Single-port byte-enable RAM controller with ordered 2-entry read response buffer.
// Latency: read accepted in cycle N shows rsp_valid in N+2 (empty buffer); writes retire at accept.
// Backpressure: req_ready drops when buffered + in-flight reads (minus a same-cycle pop) reach 2.
// Optional clear sweep of the whole RAM after reset: define IOB_RAM_SP_BE_CTRL_INIT_EN.
module iob_ram_sp_be_ctrl #(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iob_ram_sp_be_ctrl_if.slave   bus,
    output logic                  init_done,
    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
);
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] sweep_addr;

`ifdef IOB_RAM_SP_BE_CTRL_INIT_EN
    logic [ADDR_W-1:0] cnt_q;

    // Clear sweep: walk every address once, then serve requests forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign sweep_addr = cnt_q;
`else
    // No sweep: the controller is serving requests as soon as reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= ST_RUN;
        end
    end

    assign sweep_addr = '0;
`endif

    // Gating with rst_n forces every output to its idle value while reset is held.
    logic run;
    logic sweep;
    assign run       = rst_n & (state_q == ST_RUN);
    assign sweep     = rst_n & (state_q == ST_INIT);
    assign init_done = run;

    // Response buffer: two entries plus one read that is still inside the RAM.
    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              inflight_q;
    logic              inflight_d;

    logic       acc;
    logic       is_rd;
    logic       push;
    logic       pop;
    logic [2:0] occ;

    assign acc   = bus.req_valid & bus.req_ready;
    assign is_rd = (bus.req_wstrb == '0);
    assign push  = inflight_q;
    assign pop   = bus.rsp_valid & bus.rsp_ready;

    // Occupancy after this cycle's pop; a free slot must exist for the read about to be taken.
    assign occ           = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign bus.req_ready = run & (occ < 3'd2);
    assign bus.rsp_valid = (count_q != 2'd0);
    assign bus.rsp_rdata = fifo_q[rd_ptr_q];

    // Next occupancy and in-flight flag.
    always_comb begin
        inflight_d = acc & is_rd;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Buffer storage and pointers; reset drops any in-flight read and buffered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= ram_dout;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // RAM port: sweep owns it during INIT, otherwise it follows the accepted request.
    always_comb begin
        ram_en   = acc;
        ram_we   = acc ? bus.req_wstrb : '0;
        ram_addr = bus.req_addr;
        ram_din  = bus.req_wdata;
        if (sweep) begin
            ram_en   = 1'b1;
            ram_we   = '1;
            ram_addr = sweep_addr;
            ram_din  = INIT_VALUE;
        end
    end
endmodule

// File: tb/tb_iob_ram_sp_be_ctrl.sv
// Bench for iob_ram_sp_be_ctrl: RAM model, per-cycle reference model compare, directed + random stimulus.
// Latency: n/a.
// Backpressure: stimulus drives rsp_ready low in directed and random phases.
module tb_iob_ram_sp_be_ctrl;
    localparam logic [31:0] INITV = 32'hA5A5A5A5;
`ifdef IOB_RAM_SP_BE_CTRL_INIT_EN
    localparam int          SWEEP   = 16;
    localparam logic [31:0] RAM_PRE = 32'h0;
`else
    localparam int          SWEEP   = 0;
    localparam logic [31:0] RAM_PRE = INITV;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [3:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;

    int total = 0;
    int bad   = 0;

    iob_ram_sp_be_ctrl_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    iob_ram_sp_be_ctrl #(.ADDR_W(4), .DATA_W(32), .INIT_VALUE(INITV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Read-first single-port RAM with byte enables and one cycle of read latency.
    logic [31:0] ram_mem [16] = '{default: RAM_PRE};
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= ram_mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: memory image plus queue of promised responses with earliest-visible cycle.
    typedef struct {
        logic [31:0] d;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] model_mem [16] = '{default: RAM_PRE};
    int          c = 0;
    int          m_out;
    bit          m_init, m_vld, m_pop, m_rdy, m_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", bus.req_ready, 1'b0);
            chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
            chk("rst_ram_en", ram_en, 1'b0);
            chk("rst_ram_we", ram_we, 4'h0);
            chk("rst_init_done", init_done, 1'b0);
            exp_q.delete();
            c = 0;
        end else begin
            m_init = (c < SWEEP);
            m_vld  = 1'b0;
            if (exp_q.size() > 0) m_vld = (exp_q[0].t <= c);
            m_pop  = m_vld && bus.rsp_ready;
            m_out  = exp_q.size() - (m_pop ? 1 : 0);
            m_rdy  = !m_init && (m_out < 2);
            m_acc  = m_rdy && bus.req_valid;

            chk("init_done", init_done, !m_init);
            chk("req_ready", bus.req_ready, m_rdy);
            chk("rsp_valid", bus.rsp_valid, m_vld);
            if (m_vld) chk("rsp_rdata", bus.rsp_rdata, exp_q[0].d);

            if (m_init) begin
                chk("sweep_en", ram_en, 1'b1);
                chk("sweep_we", ram_we, 4'hF);
                chk("sweep_addr", ram_addr, c[3:0]);
                chk("sweep_din", ram_din, INITV);
                model_mem[c[3:0]] = INITV;
            end else begin
                chk("ram_en", ram_en, m_acc);
                chk("ram_we", ram_we, m_acc ? bus.req_wstrb : 4'h0);
                if (m_acc) begin
                    chk("ram_addr", ram_addr, bus.req_addr);
                    chk("ram_din", ram_din, bus.req_wdata);
                end
            end

            if (m_pop) void'(exp_q.pop_front());
            if (m_acc) begin
                if (bus.req_wstrb == 4'h0) begin
                    e.d = model_mem[bus.req_addr];
                    e.t = c + 2;
                    exp_q.push_back(e);
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (bus.req_wstrb[b])
                            model_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
                end
            end
            c++;
        end
    end

    // Present a request and hold it until accepted; returns the number of stall cycles.
    task automatic issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output int n);
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("issue_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Wait (rsp_ready high) for the next response; lat counts cycles from the accept edge.
    task automatic get_rsp(output logic [31:0] d, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        d = bus.rsp_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("init_wait", init_done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ram_en", ram_en, 1'b0);
        chk("arst_init_done", init_done, 1'b0);
        chk("arst_req_ready", bus.req_ready, 1'b0);
        chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("arst_rsp_rdata", bus.rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_s [8];
    int          lat, st, stalls, nacc;
    bit          took;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef IOB_RAM_SP_BE_CTRL_INIT_EN
        // Interrupt the sweep at address 9, then watch it restart from 0.
        repeat (9) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sweep_at_9", ram_addr, 4'd9);
        pulse_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("resweep_en", ram_en, 1'b1);
            chk("resweep_we", ram_we, 4'hF);
            chk("resweep_addr", ram_addr, k[3:0]);
            chk("resweep_done_low", init_done, 1'b0);
        end
        @(negedge clk);
        chk("init_done_at_16", init_done, 1'b1);
`else
        @(negedge clk);
        chk("init_done_first", init_done, 1'b1);
        pulse_reset();
        @(negedge clk);
        chk("init_done_again", init_done, 1'b1);
`endif
        @(posedge clk);
        #1;

        issue(4'd7, 32'h0, 4'h0, st);
        get_rsp(rd, lat);
        chk("read7", rd, 32'hA5A5A5A5);

        issue(4'd3, 32'h11223344, 4'hF, st);
        issue(4'd3, 32'hFFFFFFFF, 4'b0101, st);
        issue(4'd3, 32'h0, 4'h0, st);
        get_rsp(rd, lat);
        chk("byte_write", rd, 32'h11FF33FF);
        chk("read_latency", lat, 2);

        issue(4'd5, 32'hDEADBEEF, 4'hF, st);
        issue(4'd5, 32'h0, 4'h0, st);
        get_rsp(rd, lat);
        chk("raw", rd, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) exp_s[i] = 32'hA5A5A5A5;
        exp_s[3] = 32'h11FF33FF;
        exp_s[5] = 32'hDEADBEEF;
        stalls = 0;
        fork
            begin
                for (int a = 0; a < 8; a++) begin
                    issue(a[3:0], 32'h0, 4'h0, st);
                    stalls += st;
                end
            end
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    chk("stream_vld", bus.rsp_valid, 1'b1);
                    chk("stream_dat", bus.rsp_rdata, exp_s[i]);
                    if (i < 7) @(negedge clk);
                end
                @(negedge clk);
                chk("stream_end", bus.rsp_valid, 1'b0);
            end
        join
        chk("stream_stalls", stalls, 0);
        @(posedge clk);
        #1;

        // Backpressure: two reads fit, the third waits.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd3;
        bus.req_wstrb = 4'h0;
        nacc          = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            took = bus.req_ready;
            @(posedge clk);
            #1;
            if (took) begin
                nacc++;
                bus.req_addr = 4'd5;
            end
        end
        bus.req_valid = 1'b0;
        chk("bp_accepts", nacc, 2);
        @(negedge clk);
        chk("bp_ready_low", bus.req_ready, 1'b0);
        chk("bp_hold_vld", bus.rsp_valid, 1'b1);
        chk("bp_hold_dat", bus.rsp_rdata, 32'h11FF33FF);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_same_cycle", bus.req_ready, 1'b1);
        chk("bp_drain0", bus.rsp_rdata, 32'h11FF33FF);
        @(negedge clk);
        chk("bp_drain1_vld", bus.rsp_valid, 1'b1);
        chk("bp_drain1", bus.rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("bp_empty", bus.rsp_valid, 1'b0);
        @(posedge clk);
        #1;

        // Reset with one response pending: it must vanish.
        bus.rsp_ready = 1'b0;
        issue(4'd7, 32'h0, 4'h0, st);
        @(negedge clk);
        @(negedge clk);
        chk("pending_vld", bus.rsp_valid, 1'b1);
        pulse_reset();
        bus.rsp_ready = 1'b1;
        wait_init();
        repeat (3) @(negedge clk);
        chk("no_stale_rsp", bus.rsp_valid, 1'b0);
        @(posedge clk);
        #1;

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_addr  = 4'($urandom_range(0, 15));
            bus.req_wdata = $urandom;
            bus.req_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
